alu_param: RTL and testbench

ALU_PARAM -- requirements
Module: alu_param

---
 rtl/alu_pkg.sv | 36 +++
 rtl/seq_muldiv.sv | 131 +++++++++++++
 rtl/alu_param.sv | 157 +++++++++++++++
 tb/tb_alu_param.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode and FSM encodings plus iteration-counter sizing.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package alu_pkg;

  localparam int WIDTH_MIN = 4;
  localparam int WIDTH_MAX = 64;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_MUL = 3'b010,
    OP_DIV = 3'b011,
    OP_AND = 3'b100,
    OP_OR  = 3'b101,
    OP_XOR = 3'b110,
    OP_SLT = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_MUL_RUN = 2'b01,
    S_DIV_RUN = 2'b10
  } state_e;

  // Bits needed to hold values 0..n-1; called with WIDTH+1 so the counter can reach WIDTH.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/seq_muldiv.sv
// Iterative signed mul/div datapath: shift-add multiply, restoring divide on magnitudes.
// Latency: load cycle plus WIDTH run cycles; last marks the run cycle whose results are final.
// Backpressure: none; the controller owns sequencing and drops requests while running.
module seq_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic                    run,
  input  logic                    is_div,
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic                    last,
  output logic signed [WIDTH-1:0] res,
  output logic signed [WIDTH-1:0] rem,
  output logic                    ovf
);

  localparam int CW = clog2(WIDTH + 1);
  localparam int W2 = 2 * WIDTH;

  // acc: product accumulator (mul) or partial remainder (div)
  // mcand: shifted multiplicand (mul) or divisor magnitude (div)
  // mplier: multiplier shifted right (mul) or dividend/quotient shifted left (div)
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [W2-1:0]    acc_q, acc_d;
  logic [W2-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic             is_div_q, is_div_d;
  logic             neg_q, neg_d;
  logic             rneg_q, rneg_d;

  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   r_sh, r_dvs, r_diff;
  logic             r_ge;
  logic [W2-1:0]    prod;
  logic [WIDTH-1:0] quo;

  // Operand magnitudes and the restoring-division trial subtract.
  always_comb begin
    a_mag  = a[WIDTH-1] ? -a : a;
    b_mag  = b[WIDTH-1] ? -b : b;
    r_sh   = {acc_q[WIDTH-1:0], mplier_q[WIDTH-1]};
    r_dvs  = {1'b0, mcand_q[WIDTH-1:0]};
    r_ge   = (r_sh >= r_dvs);
    r_diff = r_sh - r_dvs;
  end

  // Next-state: load operands, or advance one iteration while running.
  always_comb begin
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    if (load) begin
      cnt_d    = '0;
      acc_d    = '0;
      is_div_d = is_div;
      neg_d    = a[WIDTH-1] ^ b[WIDTH-1];
      rneg_d   = a[WIDTH-1];
      if (is_div) begin
        mcand_d  = {{WIDTH{1'b0}}, b_mag};
        mplier_d = a_mag;
      end else begin
        mcand_d  = {{WIDTH{1'b0}}, a_mag};
        mplier_d = b_mag;
      end
    end else if (run) begin
      cnt_d = cnt_q + CW'(1);
      if (is_div_q) begin
        acc_d    = {{(WIDTH-1){1'b0}}, (r_ge ? r_diff : r_sh)};
        mplier_d = {mplier_q[WIDTH-2:0], r_ge};
      end else begin
        if (mplier_q[0]) begin
          acc_d = acc_q + mcand_q;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
      end
    end
  end

  // Sign fix-up taken from the next-state values so the final step's results are ready on last.
  always_comb begin
    prod = neg_q ? -acc_d : acc_d;
    quo  = mplier_d;
    res  = '0;
    rem  = '0;
    ovf  = 1'b0;
    if (is_div_q) begin
      res = neg_q ? -quo : quo;
      rem = rneg_q ? -acc_d[WIDTH-1:0] : acc_d[WIDTH-1:0];
      // Only a positive quotient of 2^(WIDTH-1) (most negative / -1) cannot be represented.
      ovf = ~neg_q & quo[WIDTH-1];
    end else begin
      res = prod[WIDTH-1:0];
      // Product fits iff the upper WIDTH+1 bits are all copies of the sign.
      ovf = ~((&prod[W2-1:WIDTH-1]) | ~(|prod[W2-1:WIDTH-1]));
    end
  end

  assign last = run & (cnt_q == CW'(WIDTH - 1));

  // Iteration registers; reset clears everything, aborting any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
    end
  end

endmodule

// File: rtl/alu_param.sv
// Parameterised signed ALU: single-cycle add/sub/logic/slt, iterative mul/div via seq_muldiv.
// Latency: done one cycle after start for single-cycle ops and div-by-zero, WIDTH+1 for mul/div.
// Backpressure: start is ignored (not queued) while busy; start alongside done is accepted.
module alu_param
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [2:0]              opcode,
  input  logic signed [WIDTH-1:0] A,
  input  logic signed [WIDTH-1:0] B,
  output logic signed [WIDTH-1:0] result,
  output logic signed [WIDTH-1:0] remainder,
  output logic                    done,
  output logic                    busy,
  output logic                    overflow,
  output logic                    div_by_zero
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             done_q, done_d;
  logic             ovf_q, ovf_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH-1:0] sum, diff;
  logic             add_ovf, sub_ovf, slt_bit;

  logic                    seq_load, seq_run, seq_is_div, seq_last, seq_ovf;
  logic signed [WIDTH-1:0] seq_res, seq_rem;

  // Single-cycle arithmetic; overflow when operand signs allow it and the result sign flips.
  always_comb begin
    sum     = A + B;
    diff    = A - B;
    add_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
    sub_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
    slt_bit = (A < B);
  end

  assign seq_is_div = (opcode == OP_DIV);

  seq_muldiv #(
    .WIDTH(WIDTH)
  ) u_seq (
    .clk    (clk),
    .reset  (reset),
    .load   (seq_load),
    .run    (seq_run),
    .is_div (seq_is_div),
    .a      (A),
    .b      (B),
    .last   (seq_last),
    .res    (seq_res),
    .rem    (seq_rem),
    .ovf    (seq_ovf)
  );

  // Control FSM: accept start in IDLE, launch iterative ops, retire them on the last step.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    rem_d    = rem_q;
    ovf_d    = ovf_q;
    dbz_d    = dbz_q;
    done_d   = 1'b0;
    seq_load = 1'b0;
    seq_run  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (op_e'(opcode))
            OP_MUL: begin
              seq_load = 1'b1;
              state_d  = S_MUL_RUN;
            end
            OP_DIV: begin
              if (B == '0) begin
                result_d = '1;
                rem_d    = A;
                ovf_d    = 1'b0;
                dbz_d    = 1'b1;
                done_d   = 1'b1;
              end else begin
                seq_load = 1'b1;
                state_d  = S_DIV_RUN;
              end
            end
            default: begin
              rem_d  = '0;
              ovf_d  = 1'b0;
              dbz_d  = 1'b0;
              done_d = 1'b1;
              case (op_e'(opcode))
                OP_ADD: begin
                  result_d = sum;
                  ovf_d    = add_ovf;
                end
                OP_SUB: begin
                  result_d = diff;
                  ovf_d    = sub_ovf;
                end
                OP_AND:  result_d = A & B;
                OP_OR:   result_d = A | B;
                OP_XOR:  result_d = A ^ B;
                default: result_d = {{(WIDTH-1){1'b0}}, slt_bit};
              endcase
            end
          endcase
        end
      end
      S_MUL_RUN, S_DIV_RUN: begin
        seq_run = 1'b1;
        if (seq_last) begin
          result_d = seq_res;
          rem_d    = seq_rem;
          ovf_d    = seq_ovf;
          dbz_d    = 1'b0;
          done_d   = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and result registers; outputs hold until the next done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      rem_q    <= '0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      rem_q    <= rem_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
      dbz_q    <= dbz_d;
    end
  end

  assign result      = result_q;
  assign remainder   = rem_q;
  assign done        = done_q;
  assign busy        = (state_q != S_IDLE);
  assign overflow    = ovf_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_alu_param.sv
// Directed self-checking bench for alu_param at WIDTH=16.
// Latency: measured from the start edge to the cycle done is observed.
// Backpressure: exercises start-while-busy and start-with-done.
module tb_alu_param;
  import alu_pkg::*;

  localparam int W = 16;

  logic                clk = 1'b0;
  logic                reset;
  logic                start;
  logic [2:0]          opcode;
  logic signed [W-1:0] A, B;
  logic signed [W-1:0] result, remainder;
  logic                done, busy, overflow, div_by_zero;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_param #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .opcode      (opcode),
    .A           (A),
    .B           (B),
    .result      (result),
    .remainder   (remainder),
    .done        (done),
    .busy        (busy),
    .overflow    (overflow),
    .div_by_zero (div_by_zero)
  );

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h, expected 0x%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present an operation for one edge, then scramble operands to prove they were captured.
  task automatic issue(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    opcode = op;
    A      = a;
    B      = b;
    start  = 1'b1;
    step();
    start  = 1'b0;
    opcode = 3'($urandom);
    A      = 16'($urandom);
    B      = 16'($urandom);
  endtask

  task automatic wait_done(input int lat0, output int lat);
    lat = lat0;
    while (!done && lat < 200) begin
      step();
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [15:0] a,
                        input logic [15:0] b, input int exp_lat, input logic [15:0] e_res,
                        input logic [15:0] e_rem, input logic e_ovf, input logic e_dbz);
    int lat;
    issue(op, a, b);
    wait_done(1, lat);
    check_eq({tag, "_lat"}, 16'(lat), 16'(exp_lat));
    check_eq({tag, "_res"}, result, e_res);
    check_eq({tag, "_rem"}, remainder, e_rem);
    check_eq({tag, "_ovf"}, 16'(overflow), 16'(e_ovf));
    check_eq({tag, "_dbz"}, 16'(div_by_zero), 16'(e_dbz));
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_res"},  result, 16'h0000);
    check_eq({tag, "_rem"},  remainder, 16'h0000);
    check_eq({tag, "_done"}, 16'(done), 16'h0000);
    check_eq({tag, "_busy"}, 16'(busy), 16'h0000);
    check_eq({tag, "_ovf"},  16'(overflow), 16'h0000);
    check_eq({tag, "_dbz"},  16'(div_by_zero), 16'h0000);
  endtask

  initial begin
    int lat;
    int dcount;

    reset  = 1'b1;
    start  = 1'b0;
    opcode = 3'b000;
    A      = '0;
    B      = '0;
    repeat (3) step();
    check_all_zero("reset");
    reset = 1'b0;
    step();

    // Single-cycle ops.
    run_op("add_ovf", OP_ADD, 16'h7FFF, 16'h0001, 1, 16'h8000, 16'h0000, 1'b1, 1'b0);
    step();
    check_eq("add_done_pulse", 16'(done), 16'h0000);
    check_eq("add_res_hold", result, 16'h8000);
    run_op("sub_ovf", OP_SUB, 16'h8000, 16'h0001, 1, 16'h7FFF, 16'h0000, 1'b1, 1'b0);
    run_op("sub",     OP_SUB, 16'd5,    16'd7,    1, 16'hFFFE, 16'h0000, 1'b0, 1'b0);
    run_op("and",     OP_AND, 16'hF0F0, 16'h0FF0, 1, 16'h00F0, 16'h0000, 1'b0, 1'b0);
    run_op("or",      OP_OR,  16'hF0F0, 16'h0FF0, 1, 16'hFFF0, 16'h0000, 1'b0, 1'b0);
    run_op("xor",     OP_XOR, 16'hF0F0, 16'h0FF0, 1, 16'hFF00, 16'h0000, 1'b0, 1'b0);
    run_op("slt_t",   OP_SLT, 16'hFFFB, 16'h0003, 1, 16'h0001, 16'h0000, 1'b0, 1'b0);
    run_op("slt_f",   OP_SLT, 16'h0003, 16'hFFFB, 1, 16'h0000, 16'h0000, 1'b0, 1'b0);

    // mul -300 * 200 with an extra start (add 1+1) thrown in while busy.
    issue(OP_MUL, 16'hFED4, 16'd200);
    check_eq("mul_busy", 16'(busy), 16'h0001);
    lat = 1;
    repeat (3) begin
      step();
      lat++;
    end
    opcode = OP_ADD;
    A      = 16'sd1;
    B      = 16'sd1;
    start  = 1'b1;
    step();
    lat++;
    start = 1'b0;
    wait_done(lat, lat);
    check_eq("mul_lat", 16'(lat), 16'd17);
    check_eq("mul_res", result, 16'h15A0);
    check_eq("mul_rem", remainder, 16'h0000);
    check_eq("mul_ovf", 16'(overflow), 16'h0001);
    check_eq("mul_dbz", 16'(div_by_zero), 16'h0000);
    step();
    check_eq("mul_done_pulse", 16'(done), 16'h0000);
    check_eq("mul_idle", 16'(busy), 16'h0000);
    check_eq("mul_res_hold", result, 16'h15A0);

    // 12 * -11, then an add issued in the very cycle done is high.
    run_op("mul_small", OP_MUL, 16'd12, 16'hFFF5, 17, 16'hFF7C, 16'h0000, 1'b0, 1'b0);
    run_op("b2b_add",   OP_ADD, 16'd2,  16'd3,    1,  16'h0005, 16'h0000, 1'b0, 1'b0);
    step();
    check_eq("b2b_done_pulse", 16'(done), 16'h0000);

    // Division cases.
    run_op("div_neg",  OP_DIV, 16'hFFF9, 16'd2,    17, 16'hFFFD, 16'hFFFF, 1'b0, 1'b0);
    run_op("div_mix",  OP_DIV, 16'd100,  16'hFFF9, 17, 16'hFFF2, 16'h0002, 1'b0, 1'b0);
    run_op("div_ovf",  OP_DIV, 16'h8000, 16'hFFFF, 17, 16'h8000, 16'h0000, 1'b1, 1'b0);
    run_op("div_zero", OP_DIV, 16'd5,    16'h0000, 1,  16'hFFFF, 16'h0005, 1'b0, 1'b1);
    run_op("div_clr",  OP_ADD, 16'd1,    16'd1,    1,  16'h0002, 16'h0000, 1'b0, 1'b0);

    // Reset at cycle 8 of a mul aborts it silently.
    issue(OP_MUL, 16'd100, 16'd100);
    repeat (7) step();
    check_eq("abort_busy_pre", 16'(busy), 16'h0001);
    reset = 1'b1;
    #1;
    check_all_zero("abort");
    step();
    reset  = 1'b0;
    dcount = 0;
    repeat (25) begin
      step();
      if (done) dcount++;
    end
    check_eq("abort_no_done", 16'(dcount), 16'h0000);
    check_eq("abort_idle", 16'(busy), 16'h0000);
    run_op("post_rst_add", OP_ADD, 16'd100, 16'd23, 1, 16'd123, 16'h0000, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
